// File: rtl/sbox_led_sequencer.sv
// sbox_led_sequencer: queues S-box result bytes in a small FIFO and shows
// each one on the LEDs for a fixed dwell time, oldest first.
//
// Handshake: a byte is transferred on a rising edge where in_valid and
// in_ready are both high. in_ready is !full and depends only on the
// registered count (the count before any pop on that same edge), so it
// never depends on in_valid. While in_ready is low, in_valid and in_data
// are ignored; nothing is stored and no error is raised.
module sbox_led_sequencer #(
    parameter int DEPTH        = 4,
    parameter int DWELL_CYCLES = 50000000,
    parameter int CNT_W        = 26
) (
    input  logic                     CLOCK_50,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [7:0]               in_data,
    output logic                     in_ready,
    input  logic                     clear,
    output logic [7:0]               led_data,
    output logic                     show_valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     dbg_state
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = PTR_W + 1;
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0]    DEPTH_CNT  = CW'(DEPTH);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SHOW = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [7:0]          r_mem [DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [CW-1:0]       r_count;
    logic [CW-1:0]       w_count_nxt;
    logic [CNT_W-1:0]    r_dwell;
    logic                w_in_ready;
    logic                w_push;
    logic                w_pop;
    logic                w_flush;

    // Flow-control flags are purely a function of the registered count.
    assign w_in_ready = (r_count != DEPTH_CNT);
    assign w_flush    = reset || clear;
    assign w_push     = in_valid && w_in_ready && !w_flush;
    assign w_pop      = (r_state == ST_SHOW) && (r_dwell == DWELL_LAST);

    assign in_ready  = w_in_ready;
    assign count     = r_count;
    assign full      = (r_count == DEPTH_CNT);
    assign empty     = (r_count == '0);
    assign dbg_state = r_state;

    // Occupancy after this edge: a simultaneous push and pop cancel out.
    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + CW'(1);
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - CW'(1);
        end
    end

    // Display FSM next state and its outputs; LEDs are dark while idle.
    always_comb begin
        w_state_nxt = r_state;
        show_valid  = 1'b0;
        led_data    = 8'h00;
        case (r_state)
            ST_IDLE: begin
                if (r_count != '0) begin
                    w_state_nxt = ST_SHOW;
                end
            end
            ST_SHOW: begin
                show_valid = 1'b1;
                led_data   = r_mem[r_rd_ptr];
                if (w_pop && (w_count_nxt == '0)) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM state register; reset and clear both return to idle.
    always_ff @(posedge CLOCK_50) begin
        if (w_flush) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FIFO storage: written on an accepted push, never cleared.
    always_ff @(posedge CLOCK_50) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    // Pointers, occupancy and dwell counter; pointers wrap naturally.
    always_ff @(posedge CLOCK_50) begin
        if (w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_dwell  <= '0;
        end else begin
            r_count <= w_count_nxt;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (r_state == ST_SHOW && !w_pop) begin
                r_dwell <= r_dwell + CNT_W'(1);
            end else begin
                r_dwell <= '0;
            end
        end
    end

endmodule
